fp_int_mul: RTL and testbench

Bit-serial FP16 × signed-INT multiplier feeding the FP-INT accumulation stage. It accepts one FP16 activation and one signed integer weight per transaction and emits the accumulator's operand set: product sign, 5-bit exponent, unsigned fixed-point magnitude, and a running minimum exponent over the current group. Products are formed by shift-add over the weight magnitude, one bit per cycle. Transactions use valid/ready handshakes on both sides.

---
 rtl/fp_int_pkg.sv | 22 ++
 rtl/fp_int_mul_datapath.sv | 99 +++++++++
 rtl/fp_int_mul.sv | 152 +++++++++++++++
 tb/tb_fp_int_mul.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_int_pkg.sv
// Shared definitions for the FP16 x signed-INT bit-serial multiplier:
// FP16 field layout, FSM state encoding and the fixed-point width rule.
package fp_int_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'h1F;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  // The largest product is an 11-bit mantissa times a (W-1)-bit magnitude,
  // so MANT_W + W - 1 bits always hold it.
  function automatic int fpw_of(input int w);
    return MANT_W + w - 1;
  endfunction

endpackage

// File: rtl/fp_int_mul_datapath.sv
// Operand capture and shift-add engine for fp_int_mul.
// Holds the operand registers, the accumulator and the step down-counter.
// With FP_INT_MUL_ZERO_SKIP_EN defined it also exposes the decoded operands
// combinationally so the top can bypass the multiply loop on zero products.
module fp_int_mul_datapath
  import fp_int_pkg::*;
#(
  parameter int W   = 4,
  parameter int FPW = fpw_of(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [15:0]      fp_in,
  input  logic [W-1:0]     w_in,
  input  logic             in_first,
`ifdef FP_INT_MUL_ZERO_SKIP_EN
  output logic             cap_zero,
  output logic             cap_sign,
  output logic [EXP_W-1:0] cap_exp,
  output logic             cap_special,
`endif
  output logic             sign_q,
  output logic [EXP_W-1:0] exp_q,
  output logic             special_q,
  output logic             first_q,
  output logic [FPW-1:0]   acc,
  output logic             mul_done
);

  localparam int CW = $clog2(W);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac;
  logic [MANT_W-1:0] mant_c;
  logic [EXP_W-1:0]  eff_exp_c;
  logic              sign_c;
  logic              special_c;
  logic [W-1:0]      w_abs;
  logic [W-2:0]      wmag_c;

  logic [FPW-1:0]    mant_sh;
  logic [W-2:0]      wmag_sh;
  logic [CW-1:0]     cnt;

  // Decode the incoming operands; the most negative weight saturates to the
  // largest positive magnitude so it fits in W-1 bits.
  always_comb begin
    exp_f     = fp_in[FRAC_W +: EXP_W];
    frac      = fp_in[FRAC_W-1:0];
    mant_c    = {(exp_f != '0), frac};
    eff_exp_c = (exp_f == '0) ? EXP_W'(1) : exp_f;
    sign_c    = fp_in[EXP_W+FRAC_W] ^ w_in[W-1];
    special_c = (exp_f == EXP_SPECIAL);
    w_abs     = w_in[W-1] ? (~w_in + W'(1)) : w_in;
    wmag_c    = w_abs[W-1] ? '1 : w_abs[W-2:0];
  end

`ifdef FP_INT_MUL_ZERO_SKIP_EN
  assign cap_zero    = (wmag_c == '0) || (mant_c == '0);
  assign cap_sign    = sign_c;
  assign cap_exp     = eff_exp_c;
  assign cap_special = special_c;
`endif

  assign mul_done = (cnt == '0);

  // Capture on handshake, then one weight bit per step, LSB first: the
  // mantissa shifts left while the weight shifts right, and the counter
  // runs down to zero to mark the end of the loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_sh   <= '0;
      wmag_sh   <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      special_q <= 1'b0;
      first_q   <= 1'b0;
    end else if (load) begin
      mant_sh   <= FPW'(mant_c);
      wmag_sh   <= wmag_c;
      acc       <= '0;
      cnt       <= CW'(W-1);
      sign_q    <= sign_c;
      exp_q     <= eff_exp_c;
      special_q <= special_c;
      first_q   <= in_first;
    end else if (step) begin
      if (wmag_sh[0]) acc <= acc + mant_sh;
      mant_sh <= mant_sh << 1;
      wmag_sh <= wmag_sh >> 1;
      cnt     <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fp_int_mul.sv
// Bit-serial FP16 x signed-INT multiplier producing the accumulator operand
// set (sign, exponent, fixed-point magnitude, running group exponent min).
// Optional macro FP_INT_MUL_ZERO_SKIP_EN: zero products bypass the multiply
// loop and go straight from IDLE to HOLD.
module fp_int_mul
  import fp_int_pkg::*;
#(
  parameter int W   = 4,
  parameter int FPW = fpw_of(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic [15:0]      fp_in,
  input  logic [W-1:0]     w_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [FPW-1:0]   fixed_point_out,
  output logic [EXP_W-1:0] exp_min_out,
  output logic             special_out
);

  state_t state, state_next;

  logic             load;
  logic             step;
  logic             res_load;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic             special_q;
  logic             first_q;
  logic [FPW-1:0]   acc;
  logic             mul_done;
  logic [EXP_W-1:0] exp_min;

`ifdef FP_INT_MUL_ZERO_SKIP_EN
  logic             skip_load;
  logic             cap_zero;
  logic             cap_sign;
  logic [EXP_W-1:0] cap_exp;
  logic             cap_special;
`endif

  function automatic logic [EXP_W-1:0] min_exp(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  fp_int_mul_datapath #(.W(W), .FPW(FPW)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .fp_in       (fp_in),
    .w_in        (w_in),
    .in_first    (in_first),
`ifdef FP_INT_MUL_ZERO_SKIP_EN
    .cap_zero    (cap_zero),
    .cap_sign    (cap_sign),
    .cap_exp     (cap_exp),
    .cap_special (cap_special),
`endif
    .sign_q      (sign_q),
    .exp_q       (exp_q),
    .special_q   (special_q),
    .first_q     (first_q),
    .acc         (acc),
    .mul_done    (mul_done)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == HOLD);
  assign exp_min_out = exp_min;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control. MUL spends W-1 cycles adding and one
  // final cycle (counter at zero) handing the sum to the output registers.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    res_load   = 1'b0;
`ifdef FP_INT_MUL_ZERO_SKIP_EN
    skip_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
`ifdef FP_INT_MUL_ZERO_SKIP_EN
          if (cap_zero) begin
            skip_load  = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = MUL;
          end
`else
          state_next = MUL;
`endif
        end
      end
      MUL: begin
        if (mul_done) begin
          res_load   = 1'b1;
          state_next = HOLD;
        end else begin
          step = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers and group exponent minimum, updated on entry to HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_out        <= 1'b0;
      exp_out         <= '0;
      fixed_point_out <= '0;
      special_out     <= 1'b0;
      exp_min         <= EXP_SPECIAL;
    end else if (res_load) begin
      sign_out        <= sign_q;
      exp_out         <= exp_q;
      fixed_point_out <= acc;
      special_out     <= special_q;
      exp_min         <= first_q ? exp_q : min_exp(exp_min, exp_q);
    end
`ifdef FP_INT_MUL_ZERO_SKIP_EN
    else if (skip_load) begin
      sign_out        <= cap_sign;
      exp_out         <= cap_exp;
      fixed_point_out <= '0;
      special_out     <= cap_special;
      exp_min         <= in_first ? cap_exp : min_exp(exp_min, cap_exp);
    end
`endif
  end

endmodule

// File: tb/tb_fp_int_mul.sv
// Self-checking bench for fp_int_mul (W = 4): directed vector table,
// randomized transactions against an arithmetic reference model, and
// hand-written backpressure / asynchronous reset sequences.
module tb_fp_int_mul;

  localparam int W   = 4;
  localparam int FPW = 14;
`ifdef FP_INT_MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_first;
  logic [15:0]    fp_in;
  logic [W-1:0]   w_in;
  logic           out_valid;
  logic           out_ready;
  logic           sign_out;
  logic [4:0]     exp_out;
  logic [FPW-1:0] fixed_point_out;
  logic [4:0]     exp_min_out;
  logic           special_out;

  int tests_run = 0;
  int tests_failed = 0;
  int model_min = 31;

  typedef struct {
    logic [15:0] fp;
    logic [3:0]  w;
    logic        first;
    logic        sgn;
    int          ex;
    int          fx;
    logic        sp;
    int          mn;
  } vec_t;

  always #5 clk = ~clk;

  fp_int_mul #(.W(W), .FPW(FPW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_first        (in_first),
    .fp_in           (fp_in),
    .w_in            (w_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sign_out        (sign_out),
    .exp_out         (exp_out),
    .fixed_point_out (fixed_point_out),
    .exp_min_out     (exp_min_out),
    .special_out     (special_out)
  );

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: value-level arithmetic on the FP16 fields and integer weight.
  task automatic ref_model(input logic [15:0] fp, input logic [3:0] w,
                           input logic first, output vec_t v);
    int e, mant, wv, mag;
    e    = int'(fp[14:10]);
    mant = int'(fp[9:0]) + ((e != 0) ? 1024 : 0);
    wv   = $signed(w);
    mag  = (wv < 0) ? -wv : wv;
    if (mag > 7) mag = 7;
    v.fp    = fp;
    v.w     = w;
    v.first = first;
    v.ex    = (e == 0) ? 1 : e;
    v.fx    = mant * mag;
    v.sgn   = fp[15] ^ (wv < 0);
    v.sp    = (e == 31);
    v.mn    = first ? v.ex : ((model_min < v.ex) ? model_min : v.ex);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    check({tag, " sign"},    int'(sign_out), int'(v.sgn));
    check({tag, " exp"},     int'(exp_out), v.ex);
    check({tag, " fixed"},   int'(fixed_point_out), v.fx);
    check({tag, " special"}, int'(special_out), int'(v.sp));
    check({tag, " exp_min"}, int'(exp_min_out), v.mn);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int k;
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    fp_in     = v.fp;
    w_in      = v.w;
    in_first  = v.first;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(k);
    lat = (SKIP && v.fx == 0) ? 0 : W;
    check({tag, " latency"}, k, lat);
    check_result(v, tag);
    model_min = v.mn;
    @(posedge clk); #1;
    check({tag, " idle_after"}, int'(in_ready), 1);
  endtask

  vec_t table_v[11];

  initial begin
    vec_t v;
    vec_t snap;
    int k;

    table_v[0]  = '{16'h3C00, 4'd3,  1'b1, 1'b0, 15, 3072, 1'b0, 15};
    table_v[1]  = '{16'hBE00, 4'hE,  1'b1, 1'b0, 15, 3072, 1'b0, 15};
    table_v[2]  = '{16'h3C00, 4'h8,  1'b1, 1'b1, 15, 7168, 1'b0, 15};
    table_v[3]  = '{16'h0001, 4'd1,  1'b1, 1'b0, 1,  1,    1'b0, 1};
    table_v[4]  = '{16'h5000, 4'd1,  1'b1, 1'b0, 20, 1024, 1'b0, 20};
    table_v[5]  = '{16'h3000, 4'd1,  1'b0, 1'b0, 12, 1024, 1'b0, 12};
    table_v[6]  = '{16'h4400, 4'd1,  1'b0, 1'b0, 17, 1024, 1'b0, 12};
    table_v[7]  = '{16'h4800, 4'd1,  1'b1, 1'b0, 18, 1024, 1'b0, 18};
    table_v[8]  = '{16'h7C01, 4'd2,  1'b0, 1'b0, 31, 2050, 1'b1, 18};
    table_v[9]  = '{16'h3C00, 4'd0,  1'b0, 1'b0, 15, 0,    1'b0, 15};
    table_v[10] = '{16'h8000, 4'd3,  1'b0, 1'b1, 1,  0,    1'b0, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    fp_in = '0;
    w_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset sign", int'(sign_out), 0);
    check("reset exp", int'(exp_out), 0);
    check("reset fixed", int'(fixed_point_out), 0);
    check("reset special", int'(special_out), 0);
    check("reset exp_min", int'(exp_min_out), 31);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn(table_v[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      ref_model(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Backpressure: result must hold while out_ready is low, new input ignored.
    ref_model(16'h4600, 4'hD, 1'b1, v);
    @(negedge clk);
    in_valid = 1'b1; fp_in = v.fp; w_in = v.w; in_first = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(k);
    check("bp latency", k, W);
    check_result(v, "bp");
    model_min = v.mn;
    snap = v;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; fp_in = 16'h3C00; w_in = 4'd5; in_first = 1'b1;
      #1;
      check("bp in_ready", int'(in_ready), 0);
      check("bp out_valid", int'(out_valid), 1);
      check("bp fixed stable", int'(fixed_point_out), snap.fx);
      check("bp exp_min stable", int'(exp_min_out), snap.mn);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp released in_ready", int'(in_ready), 1);
    check("bp released out_valid", int'(out_valid), 0);

    // Asynchronous reset during MUL.
    @(negedge clk);
    in_valid = 1'b1; fp_in = 16'h3C00; w_in = 4'd3; in_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mul in_ready", int'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("rst mul out_valid", int'(out_valid), 0);
    check("rst mul in_ready", int'(in_ready), 1);
    check("rst mul fixed", int'(fixed_point_out), 0);
    check("rst mul sign", int'(sign_out), 0);
    check("rst mul exp_min", int'(exp_min_out), 31);
    @(negedge clk);
    rst = 1'b0;
    model_min = 31;

    // exp_min restarts from 31 after reset even without in_first.
    ref_model(16'h2800, 4'd1, 1'b0, v);
    run_txn(v, "post_rst");

    // Asynchronous reset during HOLD.
    @(negedge clk);
    in_valid = 1'b1; fp_in = 16'h4400; w_in = 4'd6; in_first = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(k);
    check("hold out_valid", int'(out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst hold out_valid", int'(out_valid), 0);
    check("rst hold in_ready", int'(in_ready), 1);
    check("rst hold exp", int'(exp_out), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    model_min = 31;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
